// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for a 32-bit async SRAM chip on the CE_n/OE_n/WE_n/be_n pin protocol.
// Pins are registered every clk; reads wait READ_LAT cycles and writes commit when the write pulse ends.
module sram_responder #(
    parameter int ADDR_W   = 12,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] ramAddr_i,
    input  logic        CE_n_i,
    input  logic        OE_n_i,
    input  logic        WE_n_i,
    input  logic [3:0]  be_n_i,
    inout  wire  [31:0] data_io,
    output logic        busy_o
);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(READ_LAT - 1);
    localparam logic [1:0] IDLE = 2'd0, RD_WAIT = 2'd1, RD_DRIVE = 2'd2, WR = 2'd3;

    logic [31:0]       mem [2**ADDR_W];
    logic              ce_s, oe_s, we_s;
    logic [3:0]        be_s, wr_be;
    logic [ADDR_W-1:0] addr_s, rd_addr, wr_addr;
    logic [31:0]       data_s, wr_data, read_data;
    logic              wr_valid;
    logic [1:0]        state, state_nx;
    logic [CW-1:0]     cnt;
    logic              rd_req, wr_req, restart, commit;
    logic              unused_addr;

    assign unused_addr = ^ramAddr_i[19:ADDR_W];
    assign rd_req = !ce_s && !oe_s && we_s;
    assign wr_req = !ce_s && !we_s;
    // A read (re)starts from IDLE/WR or whenever the sampled address moves away from the one being read
    assign restart = rd_req && !wr_req && (state == IDLE || state == WR || addr_s != rd_addr);
    assign commit = state == WR && wr_valid && !wr_req;
    assign state_nx = wr_req ? WR :
                      !rd_req ? IDLE :
                      restart ? RD_WAIT :
                      (state == RD_DRIVE || cnt == '0) ? RD_DRIVE : RD_WAIT;
    assign busy_o = (state == RD_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_s      <= 1'b1;
            oe_s      <= 1'b1;
            we_s      <= 1'b1;
            be_s      <= 4'hF;
            addr_s    <= '0;
            data_s    <= '0;
            state     <= IDLE;
            cnt       <= '0;
            rd_addr   <= '0;
            read_data <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_be     <= 4'hF;
        end else begin
            ce_s   <= CE_n_i;
            oe_s   <= OE_n_i;
            we_s   <= WE_n_i;
            be_s   <= be_n_i;
            addr_s <= ramAddr_i[ADDR_W-1:0];
            data_s <= data_io;
            state  <= state_nx;
            if (restart) begin
                cnt     <= RELOAD;
                rd_addr <= addr_s;
            end else if (state == RD_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state_nx == RD_DRIVE)
                read_data <= mem[addr_s];
            if (wr_req) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr_s;
                wr_data  <= data_s;
                wr_be    <= be_s;
            end else if (commit) begin
                wr_valid <= 1'b0;
            end
        end
    end

    // Array is left uncleared so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (commit)
            for (int j = 0; j < 4; j++)
                if (!wr_be[j])
                    mem[wr_addr][8*j +: 8] <= wr_data[8*j +: 8];
    end

    // Gated on live pins so the bus releases the same cycle the controller drops OE_n
    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign data_io[8*k +: 8] = (state == RD_DRIVE && !CE_n_i && !OE_n_i && WE_n_i && !be_n_i[k])
                                   ? read_data[8*k +: 8] : 8'bz;
    end
endmodule
